// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// State codes match the legacy CPU ALU encoding.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  typedef struct packed {
    logic cout;
    logic ovf;
  } flags_t;

  // A request is taken only while the sequencer is not mid-operation.
  function automatic logic can_accept(input state_t st);
    return (st == S_IDLE) || (st == S_DONE);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a client and the serial add/subtract sequencer.
// Handshake: start is sampled only while busy is low; done is a one-cycle valid for sum/cout/ovf.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  state_t           dbg_state;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, dbg_state
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, dbg_state
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder slice built from two half adders; the only arithmetic the
// serial sequencer owns.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full-adder slice, LSB first,
// WIDTH steps per operation, result and flags registered on the final step.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  flags_t             flags_q, flags_d;

  logic               fa_s;
  logic               fa_co;
  logic               accept;
  logic [WIDTH-1:0]   shadow_next;

  bit_full_adder u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept      = can_accept(state_q) && bus.start;
  assign shadow_next = {fa_s, shadow_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shadow_d = shadow_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        shadow_d = shadow_next;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        // carry_q here is the carry into the MSB, so overflow falls out directly.
        if (cnt_q == LAST_BIT) begin
          state_d      = S_DONE;
          sum_d        = shadow_next;
          flags_d.cout = fa_co;
          flags_d.ovf  = carry_q ^ fa_co;
        end
      end
      S_DONE: begin
        state_d = bus.start ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Subtraction is a + ~b + 1: invert B at capture and force the carry-in.
    if (accept) begin
      opa_d    = bus.a;
      opb_d    = bus.b ^ {WIDTH{bus.sub}};
      carry_d  = bus.sub ? 1'b1 : bus.cin;
      cnt_d    = '0;
      shadow_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = flags_q.cout;
  assign bus.ovf       = flags_q.ovf;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed corner cases plus random
// add/subtract traffic checked against an integer-arithmetic reference model.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];
  int chk_cnt    = 0;
  int pass_cnt   = 0;
  int dones_seen = 0;
  int ops_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
    int ua, ub, sa, sb, r, sr;
    logic co, ov;
    logic [W-1:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      r  = ua + ub + int'(c);
      co = (r > 255);
      sr = sa + sb + int'(c);
    end else begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end
    ov  = (sr > 127) || (sr < -128);
    res = r[W-1:0];
    return {res, co, ov};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        dones_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(bus.sum), 32'(e[W+1:2]));
          chk("cout", 32'(bus.cout), 32'(e[1]));
          chk("ovf", 32'(bus.ovf), 32'(e[0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    if (push) begin
      exp_q.push_back(model(s, a, b, c));
      ops_pushed++;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sub   = 1'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy) bc++;
    end while (!bus.done && cyc < 40);
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_sum"},  32'(bus.sum),  32'd0);
    chk({tag, "_cout"}, 32'(bus.cout), 32'd0);
    chk({tag, "_ovf"},  32'(bus.ovf),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, bc;
    logic s, c;
    logic [W-1:0] ra, rb;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // zero add: latency and busy length
    issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    wait_done(cyc, bc);
    chk("latency_zero_add", 32'(cyc), 32'(LAT));
    chk("busy_cycles", 32'(bc), 32'(W));

    // carry and signed-overflow corners
    issue(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(cyc, bc);
    chk("latency_carry", 32'(cyc), 32'(LAT));
    issue(1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
    wait_done(cyc, bc);
    issue(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
    wait_done(cyc, bc);
    issue(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(cyc, bc);

    // start during RUN must be ignored
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bc);
    repeat (12) @(negedge clk);

    // back-to-back with start held high
    @(negedge clk);
    s = 1'($urandom); c = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
    bus.start = 1'b1; bus.sub = s; bus.cin = c; bus.a = ra; bus.b = rb;
    exp_q.push_back(model(s, ra, rb, c));
    ops_pushed++;
    for (int i = 0; i < 5; i++) begin
      wait_done(cyc, bc);
      chk("b2b_period", 32'(cyc), 32'(LAT));
      if (i < 4) begin
        s = 1'($urandom); c = 1'($urandom); ra = W'($urandom); rb = W'($urandom);
        bus.sub = s; bus.cin = c; bus.a = ra; bus.b = rb;
        exp_q.push_back(model(s, ra, rb, c));
        ops_pushed++;
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    // reset mid-operation abandons it
    issue(1'b0, 8'h5A, 8'h33, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", 32'(dones_seen), 32'(ops_pushed));

    // random traffic
    for (int i = 0; i < 30; i++) begin
      issue(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      wait_done(cyc, bc);
      chk("latency_rand", 32'(cyc), 32'(LAT));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (15) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(dones_seen), 32'(ops_pushed));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
